// File: rtl/exe_mem_req_pkg.sv
// exe_mem_req_pkg: shared field indices, access sizes and FSM encoding for the EXE memory request unit
package exe_mem_req_pkg;
    localparam int MEM_WE = 7, LD_B = 6, LD_H = 5, LD_W = 4, LD_SE = 3, ST_B = 2, ST_H = 1, ST_W = 0;
    localparam int EXC_INT = 6, EXC_ADEF = 5, EXC_ALE = 4, EXC_BRK = 3, EXC_INE = 2, EXC_SYS = 1, EXC_ERTN = 0;
    localparam logic [1:0] SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2, S_DRAIN = 2'd3} state_t;
endpackage

// File: rtl/exe_mem_req_if.sv
// exe_mem_req_if: data-side SRAM-like request/response bus
interface exe_mem_req_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    modport master(output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok);
    modport slave(input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok);
endinterface

// File: rtl/exe_mem_req_store_align.sv
// store_align: access size, byte strobes, lane-replicated store data and misalignment from the low address bits
module store_align
    import exe_mem_req_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic        ld_b,
    input  logic        ld_h,
    input  logic        ld_w,
    input  logic        st_b,
    input  logic        st_h,
    input  logic        st_w,
    input  logic [31:0] rkd,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        ale
);
    logic is_b, is_h, is_w;
    always_comb begin
        is_b  = ld_b | st_b;
        is_h  = ld_h | st_h;
        is_w  = ld_w | st_w;
        size  = is_b ? SIZE_B : is_h ? SIZE_H : SIZE_W;
        ale   = (is_h & addr_lo[0]) | (is_w & (|addr_lo));
        wstrb = st_b ? 4'b0001 << addr_lo : st_h ? (addr_lo[1] ? 4'b1100 : 4'b0011) : st_w ? 4'b1111 : 4'b0000;
        wdata = is_b ? {4{rkd[7:0]}} : is_h ? {2{rkd[15:0]}} : rkd;
    end
endmodule

// File: rtl/exe_mem_req.sv
// exe_mem_req: EXE stage latch, address/ALE formation, data SRAM request issue and flush drain
module exe_mem_req
    import exe_mem_req_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_to_exe_valid,
    output logic        exe_allowin,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_alu_result,
    input  logic [31:0] id_base,
    input  logic [31:0] id_offset,
    input  logic        id_res_from_mem,
    input  logic [7:0]  id_mem_all,
    input  logic [31:0] id_rkd_value,
    input  logic [5:0]  id_rf_all,
    input  logic [6:0]  id_exc_rf,
    output logic        exe_ready_go,
    output logic        exe_to_mem_valid,
    input  logic        mem_allowin,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_result,
    output logic [31:0] exe_rkd_value,
    output logic        exe_res_from_mem,
    output logic [7:0]  exe_mem_all,
    output logic [5:0]  exe_rf_all,
    output logic [6:0]  exe_exc_rf,
    input  logic        cancel_exc_ertn,
    input  logic        mem_exc_flush,
    exe_mem_req_if.master data_sram
);
    state_t      state, state_nxt;
    logic        exe_valid, latch, acc, is_mem_in, ale_in, go_req;
    logic [1:0]  cnt, cnt_nxt, size_in, size_q;
    logic [3:0]  wstrb_in, wstrb_q;
    logic [31:0] addr_in, wdata_in, wdata_q;
    logic [6:0]  exc_in;

    assign addr_in = id_base + id_offset;

    store_align u_align (
        .addr_lo(addr_in[1:0]),
        .ld_b(id_mem_all[LD_B]), .ld_h(id_mem_all[LD_H]), .ld_w(id_mem_all[LD_W]),
        .st_b(id_mem_all[ST_B]), .st_h(id_mem_all[ST_H]), .st_w(id_mem_all[ST_W]),
        .rkd(id_rkd_value),
        .size(size_in), .wstrb(wstrb_in), .wdata(wdata_in), .ale(ale_in)
    );

    always_comb begin
        exc_in            = id_exc_rf;
        exc_in[EXC_ALE]   = id_exc_rf[EXC_ALE] | ale_in;
        is_mem_in         = id_res_from_mem | id_mem_all[MEM_WE];
        go_req            = is_mem_in & ~(|exc_in) & ~mem_exc_flush;
        data_sram.req     = resetn & (state == S_REQ) & (cnt != 2'd2);
        data_sram.wr      = exe_mem_all[MEM_WE];
        data_sram.size    = size_q;
        data_sram.wstrb   = wstrb_q;
        data_sram.addr    = exe_result;
        data_sram.wdata   = wdata_q;
        acc               = data_sram.req & data_sram.addr_ok;
        cnt_nxt           = cnt + {1'b0, acc} - {1'b0, data_sram.data_ok};
        // only a still-unaccepted request holds the instruction; a dropped one passes through to MEM
        exe_ready_go      = exe_valid & (state != S_REQ);
        exe_to_mem_valid  = exe_valid & exe_ready_go;
        exe_allowin       = (state != S_DRAIN) & (~exe_valid | (exe_ready_go & mem_allowin));
        latch             = exe_allowin & id_to_exe_valid & ~cancel_exc_ertn;
        state_nxt         = state;
        if (cancel_exc_ertn)
            state_nxt = (cnt_nxt != 2'd0) ? S_DRAIN : S_IDLE;
        else if (latch)
            state_nxt = go_req ? S_REQ : S_IDLE;
        else if (state == S_REQ)
            state_nxt = acc ? S_DONE : mem_exc_flush ? S_IDLE : S_REQ;
        else if (state == S_DONE && mem_allowin)
            state_nxt = S_IDLE;
        else if (state == S_DRAIN && cnt_nxt == 2'd0)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= S_IDLE;
            cnt              <= 2'd0;
            exe_valid        <= 1'b0;
            exe_pc           <= '0;
            exe_result       <= '0;
            exe_rkd_value    <= '0;
            exe_res_from_mem <= 1'b0;
            exe_mem_all      <= '0;
            exe_rf_all       <= '0;
            exe_exc_rf       <= '0;
            size_q           <= '0;
            wstrb_q          <= '0;
            wdata_q          <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            exe_valid <= cancel_exc_ertn ? 1'b0 : exe_allowin ? id_to_exe_valid : exe_valid;
            if (latch) begin
                exe_pc           <= id_pc;
                exe_result       <= is_mem_in ? addr_in : id_alu_result;
                exe_rkd_value    <= id_rkd_value;
                exe_res_from_mem <= id_res_from_mem;
                exe_mem_all      <= id_mem_all;
                exe_rf_all       <= id_rf_all;
                exe_exc_rf       <= exc_in;
                size_q           <= size_in;
                wstrb_q          <= wstrb_in;
                wdata_q          <= wdata_in;
            end
        end
    end
endmodule
